// File: rtl/mae_pipe_if.sv
// Operand/result bundle for mae_pipe: the master presents tagged operand beats,
// the slave returns the result, its valid tag and the accumulator overflow flag.
interface mae_pipe_if #(
  parameter int unsigned A_WIDTH = 18,
  parameter int unsigned B_WIDTH = 18,
  parameter int unsigned P_WIDTH = 40
);
  logic               in_valid;
  logic               acc_clr;
  logic [A_WIDTH-1:0] a;
  logic [B_WIDTH-1:0] b;
  logic [P_WIDTH-1:0] c;
  logic [P_WIDTH-1:0] p;
  logic               out_valid;
  logic               ovf;

  modport master (output in_valid, acc_clr, a, b, c, input p, out_valid, ovf);
  modport slave (input in_valid, acc_clr, a, b, c, output p, out_valid, ovf);
endinterface

// File: rtl/mae_pipe.sv
// Parametrised multiply / multiply-add / multiply-accumulate DSP cell with optional
// input, product and output registers; valid and acc-clear tags ride with the data.
module mae_pipe #(
  parameter int unsigned A_WIDTH  = 18,
  parameter int unsigned B_WIDTH  = 18,
  parameter int unsigned P_WIDTH  = 40,
  parameter int unsigned MODE     = 0,
  parameter int unsigned SIGNED   = 1,
  parameter int unsigned REG_IN   = 1,
  parameter int unsigned REG_MULT = 1,
  parameter int unsigned REG_OUT  = 1
) (
  input  logic      clk_i,
  input  logic      srst_i,
  input  logic      en_i,
  mae_pipe_if.slave mae_io
);
  localparam int unsigned ProdW = A_WIDTH + B_WIDTH;

  logic               vld_s1, clr_s1;
  logic [A_WIDTH-1:0] a_s1;
  logic [B_WIDTH-1:0] b_s1;
  logic [P_WIDTH-1:0] c_s1;

  if (REG_IN != 0) begin : g_in_reg
    logic               vld_q, clr_q;
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic [P_WIDTH-1:0] c_q;
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        vld_q <= 1'b0;
        clr_q <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        c_q   <= '0;
      end else if (en_i) begin
        vld_q <= mae_io.in_valid;
        clr_q <= mae_io.acc_clr;
        a_q   <= mae_io.a;
        b_q   <= mae_io.b;
        c_q   <= mae_io.c;
      end
    end
    assign vld_s1 = vld_q;
    assign clr_s1 = clr_q;
    assign a_s1   = a_q;
    assign b_s1   = b_q;
    assign c_s1   = c_q;
  end else begin : g_in_wire
    assign vld_s1 = mae_io.in_valid;
    assign clr_s1 = mae_io.acc_clr;
    assign a_s1   = mae_io.a;
    assign b_s1   = mae_io.b;
    assign c_s1   = mae_io.c;
  end

  // Full-width product, then extended to P_WIDTH according to operand signedness.
  logic [ProdW-1:0]   prod_raw;
  logic [P_WIDTH-1:0] prod_s1;
  if (SIGNED != 0) begin : g_mul_signed
    assign prod_raw = ProdW'($signed(a_s1)) * ProdW'($signed(b_s1));
    assign prod_s1  = P_WIDTH'($signed(prod_raw));
  end else begin : g_mul_unsigned
    assign prod_raw = ProdW'(a_s1) * ProdW'(b_s1);
    assign prod_s1  = P_WIDTH'(prod_raw);
  end

  logic               vld_s2, clr_s2;
  logic [P_WIDTH-1:0] prod_s2, c_s2;

  if (REG_MULT != 0) begin : g_mult_reg
    logic               vld_q, clr_q;
    logic [P_WIDTH-1:0] prod_q, c_q;
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        vld_q  <= 1'b0;
        clr_q  <= 1'b0;
        prod_q <= '0;
        c_q    <= '0;
      end else if (en_i) begin
        vld_q  <= vld_s1;
        clr_q  <= clr_s1;
        prod_q <= prod_s1;
        c_q    <= c_s1;
      end
    end
    assign vld_s2  = vld_q;
    assign clr_s2  = clr_q;
    assign prod_s2 = prod_q;
    assign c_s2    = c_q;
  end else begin : g_mult_wire
    assign vld_s2  = vld_s1;
    assign clr_s2  = clr_s1;
    assign prod_s2 = prod_s1;
    assign c_s2    = c_s1;
  end

  logic               vld_out;
  logic [P_WIDTH-1:0] p_out;
  logic               ovf_out;

  if (MODE == 2) begin : g_acc
    // The accumulator is the output register, so there is always one stage here.
    logic [P_WIDTH-1:0] acc_q, acc_d;
    logic               ovf_q, ovf_d, vld_q;
    logic [P_WIDTH:0]   sum;
    logic               add_ovf;
    logic               unused_c;

    assign sum      = {1'b0, acc_q} + {1'b0, prod_s2};
    assign add_ovf  = (SIGNED != 0) ?
                      ((acc_q[P_WIDTH-1] == prod_s2[P_WIDTH-1]) &&
                       (sum[P_WIDTH-1] != acc_q[P_WIDTH-1])) : sum[P_WIDTH];
    assign unused_c = ^c_s2;

    always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (vld_s2) begin
        if (clr_s2) begin
          acc_d = prod_s2;
          ovf_d = 1'b0;
        end else begin
          acc_d = sum[P_WIDTH-1:0];
          ovf_d = ovf_q | add_ovf;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
        vld_q <= 1'b0;
      end else if (en_i) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
        vld_q <= vld_s2;
      end
    end

    assign p_out   = acc_q;
    assign ovf_out = ovf_q;
    assign vld_out = vld_q;
  end else begin : g_arith
    logic [P_WIDTH-1:0] res;
    logic               unused_clr;

    assign res        = (MODE == 1) ? prod_s2 + c_s2 : prod_s2;
    assign ovf_out    = 1'b0;
    assign unused_clr = clr_s2;

    if (REG_OUT != 0) begin : g_out_reg
      logic [P_WIDTH-1:0] p_q;
      logic               vld_q;
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          p_q   <= '0;
          vld_q <= 1'b0;
        end else if (en_i) begin
          p_q   <= res;
          vld_q <= vld_s2;
        end
      end
      assign p_out   = p_q;
      assign vld_out = vld_q;
    end else begin : g_out_wire
      assign p_out   = res;
      assign vld_out = vld_s2;
    end
  end

  // A frozen stage still holds its last beat; only an enabled cycle delivers it.
  assign mae_io.p         = p_out;
  assign mae_io.out_valid = vld_out & en_i;
  assign mae_io.ovf       = ovf_out;
endmodule

// File: tb/tb_mae_pipe.sv
// Bench for mae_pipe: six configurations share one beat stream and are checked
// against a beat-indexed arithmetic model plus directed scenarios.
module tb_mae_pipe;
  localparam int NDut = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst, en, in_valid, acc_clr;
  logic [19:0] a, b;
  logic [39:0] c;
  int checks = 0;
  int errors = 0;

  mae_pipe_if #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(40)) bus0 ();
  mae_pipe_if #(.A_WIDTH(20), .B_WIDTH(20), .P_WIDTH(40)) bus1 ();
  mae_pipe_if #(.A_WIDTH(20), .B_WIDTH(20), .P_WIDTH(40)) bus2 ();
  mae_pipe_if #(.A_WIDTH(20), .B_WIDTH(20), .P_WIDTH(40)) bus3 ();
  mae_pipe_if #(.A_WIDTH(20), .B_WIDTH(20), .P_WIDTH(40)) bus4 ();
  mae_pipe_if #(.A_WIDTH(20), .B_WIDTH(20), .P_WIDTH(40)) bus5 ();

  mae_pipe #(.MODE(0), .SIGNED(1)) u0 (
    .clk_i(clk), .srst_i(srst), .en_i(en), .mae_io(bus0));
  mae_pipe #(.A_WIDTH(20), .B_WIDTH(20), .P_WIDTH(40), .MODE(1), .SIGNED(1),
             .REG_IN(0), .REG_MULT(0), .REG_OUT(0)) u1 (
    .clk_i(clk), .srst_i(srst), .en_i(en), .mae_io(bus1));
  mae_pipe #(.A_WIDTH(20), .B_WIDTH(20), .P_WIDTH(40), .MODE(2), .SIGNED(0),
             .REG_IN(1), .REG_MULT(1), .REG_OUT(1)) u2 (
    .clk_i(clk), .srst_i(srst), .en_i(en), .mae_io(bus2));
  mae_pipe #(.A_WIDTH(20), .B_WIDTH(20), .P_WIDTH(40), .MODE(2), .SIGNED(1),
             .REG_IN(1), .REG_MULT(0), .REG_OUT(0)) u3 (
    .clk_i(clk), .srst_i(srst), .en_i(en), .mae_io(bus3));
  mae_pipe #(.A_WIDTH(20), .B_WIDTH(20), .P_WIDTH(40), .MODE(1), .SIGNED(0),
             .REG_IN(1), .REG_MULT(1), .REG_OUT(0)) u4 (
    .clk_i(clk), .srst_i(srst), .en_i(en), .mae_io(bus4));
  mae_pipe #(.A_WIDTH(20), .B_WIDTH(20), .P_WIDTH(40), .MODE(0), .SIGNED(0),
             .REG_IN(0), .REG_MULT(1), .REG_OUT(1)) u5 (
    .clk_i(clk), .srst_i(srst), .en_i(en), .mae_io(bus5));

  logic [39:0] p_o   [NDut];
  logic        vld_o [NDut];
  logic        ovf_o [NDut];
  assign p_o[0] = bus0.p;  assign vld_o[0] = bus0.out_valid;  assign ovf_o[0] = bus0.ovf;
  assign p_o[1] = bus1.p;  assign vld_o[1] = bus1.out_valid;  assign ovf_o[1] = bus1.ovf;
  assign p_o[2] = bus2.p;  assign vld_o[2] = bus2.out_valid;  assign ovf_o[2] = bus2.ovf;
  assign p_o[3] = bus3.p;  assign vld_o[3] = bus3.out_valid;  assign ovf_o[3] = bus3.ovf;
  assign p_o[4] = bus4.p;  assign vld_o[4] = bus4.out_valid;  assign ovf_o[4] = bus4.ovf;
  assign p_o[5] = bus5.p;  assign vld_o[5] = bus5.out_valid;  assign ovf_o[5] = bus5.ovf;

  // Configuration table for the model: mode, signedness, latency, operand width.
  function automatic int cfg_mode(int d);
    case (d)
      0: return 0;  1: return 1;  2: return 2;  3: return 2;  4: return 1;  default: return 0;
    endcase
  endfunction
  function automatic int cfg_signed(int d);
    return (d == 0 || d == 1 || d == 3) ? 1 : 0;
  endfunction
  function automatic int cfg_lat(int d);
    case (d)
      0: return 3;  1: return 0;  2: return 3;  default: return 2;
    endcase
  endfunction
  function automatic int cfg_aw(int d);
    return (d == 0) ? 18 : 20;
  endfunction

  typedef struct {
    logic        v;
    logic        clr;
    logic [19:0] a;
    logic [19:0] b;
    logic [39:0] c;
  } beat_t;

  // Beats accepted on enabled cycles since the last reset, oldest first.
  beat_t hist[$];

  function automatic longint opnd(logic [19:0] x, int w, int sgn);
    longint v;
    v = longint'(x) & ((longint'(1) << w) - 1);
    if (sgn != 0 && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic longint sx40(logic [39:0] x, int sgn);
    longint v;
    v = longint'(x);
    if (sgn != 0 && x[39]) v = v - (longint'(1) << 40);
    return v;
  endfunction

  function automatic logic [39:0] mprod(beat_t bt, int d);
    longint pr;
    pr = opnd(bt.a, cfg_aw(d), cfg_signed(d)) * opnd(bt.b, cfg_aw(d), cfg_signed(d));
    return pr[39:0];
  endfunction

  task automatic expect_out(input int d, output logic ev, output logic [39:0] ep,
                            output logic eo, output logic cp);
    beat_t       cur, bt;
    int          j, sg;
    logic [39:0] acc;
    logic        ov;
    longint      s;
    cur = '{v: in_valid, clr: acc_clr, a: a, b: b, c: c};
    j   = hist.size() - cfg_lat(d);
    sg  = cfg_signed(d);
    ev = 1'b0; ep = '0; eo = 1'b0; cp = 1'b1;
    if (j >= 0) begin
      if (cfg_mode(d) < 2) begin
        bt = (j == hist.size()) ? cur : hist[j];
        ev = en & bt.v;
        ep = mprod(bt, d);
        if (cfg_mode(d) == 1) ep = ep + bt.c;
        cp = ev;
      end else begin
        acc = '0;
        ov  = 1'b0;
        for (int i = 0; i <= j; i++) begin
          if (hist[i].v) begin
            if (hist[i].clr) begin
              acc = mprod(hist[i], d);
              ov  = 1'b0;
            end else begin
              s = sx40(acc, sg) + sx40(mprod(hist[i], d), sg);
              if (sg != 0) begin
                if (s > (longint'(1) << 39) - 1 || s < -(longint'(1) << 39)) ov = 1'b1;
              end else if (s >= (longint'(1) << 40)) begin
                ov = 1'b1;
              end
              acc = s[39:0];
            end
          end
        end
        ev = en & hist[j].v;
        ep = acc;
        eo = ov;
      end
    end
  endtask

  task automatic drive();
    bus0.in_valid = in_valid; bus0.acc_clr = acc_clr; bus0.a = a[17:0]; bus0.b = b[17:0];
    bus0.c = c;
    bus1.in_valid = in_valid; bus1.acc_clr = acc_clr; bus1.a = a; bus1.b = b; bus1.c = c;
    bus2.in_valid = in_valid; bus2.acc_clr = acc_clr; bus2.a = a; bus2.b = b; bus2.c = c;
    bus3.in_valid = in_valid; bus3.acc_clr = acc_clr; bus3.a = a; bus3.b = b; bus3.c = c;
    bus4.in_valid = in_valid; bus4.acc_clr = acc_clr; bus4.a = a; bus4.b = b; bus4.c = c;
    bus5.in_valid = in_valid; bus5.acc_clr = acc_clr; bus5.a = a; bus5.b = b; bus5.c = c;
  endtask

  // Record the beat the DUTs sample at the coming edge, then step past that edge.
  task automatic advance();
    beat_t cur;
    cur = '{v: in_valid, clr: acc_clr, a: a, b: b, c: c};
    if (srst) hist.delete();
    else if (en) hist.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(logic v, logic clr, logic [19:0] av, logic [19:0] bv,
                          logic [39:0] cv);
    in_valid = v; acc_clr = clr; a = av; b = bv; c = cv;
    drive();
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      set_beat(1'b0, 1'b0, '0, '0, '0);
      advance();
    end
  endtask

  function automatic logic [19:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 20'h80000;
      1:       return 20'h7FFFF;
      2:       return 20'($urandom_range(0, 15));
      default: return 20'($urandom);
    endcase
  endfunction

  task automatic rnd_beat();
    set_beat(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), rnd_op(),
             rnd_op(), {8'($urandom), 32'($urandom)});
  endtask

  task automatic test_reset();
    srst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rnd_beat();
      advance();
    end
    srst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_beat(1'b0, 1'b0, '0, '0, '0);
      for (int d = 0; d < NDut; d++) begin
        checks++;
        if (vld_o[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset_valid dut%0d k=%0d: got %b want 0", d, k, vld_o[d]);
        end
        if (k == 0) begin
          checks += 2;
          if (p_o[d] !== 40'd0) begin
            errors++;
            $display("FAIL reset_p dut%0d: got %h want 0", d, p_o[d]);
          end
          if (ovf_o[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf dut%0d: got %b want 0", d, ovf_o[d]);
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_mode0();
    logic [39:0] m21;
    m21 = -40'sd21;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) set_beat(1'b1, 1'b0, 20'hFFFFD, 20'd7, '0);
      else set_beat(1'b0, 1'b0, '0, '0, '0);
      checks++;
      if (vld_o[0] !== (k == 3)) begin
        errors++;
        $display("FAIL mode0_valid k=%0d: got %b want %b", k, vld_o[0], (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (p_o[0] !== m21) begin
          errors++;
          $display("FAIL mode0_p: got %h want %h", p_o[0], m21);
        end
      end
      advance();
    end
  endtask

  task automatic test_mode1_comb();
    set_beat(1'b1, 1'b0, 20'd100, 20'd200, 40'd5);
    checks += 2;
    if (p_o[1] !== 40'd20005 || vld_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL mode1_comb: got p=%0d v=%b want p=20005 v=1", p_o[1], vld_o[1]);
    end
    set_beat(1'b0, 1'b0, 20'd100, 20'd200, 40'd5);
    if (vld_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL mode1_novalid: got v=%b want 0", vld_o[1]);
    end
    advance();
    idle(4);
  endtask

  task automatic test_accum_unsigned();
    logic [39:0] exp_p [5];
    exp_p = '{40'd2, 40'd6, 40'd12, 40'd20, 40'd10};
    for (int k = 0; k < 10; k++) begin
      if (k < 4) set_beat(1'b1, (k == 0), 20'(k + 1), 20'd2, '0);
      else if (k == 4) set_beat(1'b1, 1'b1, 20'd5, 20'd2, '0);
      else set_beat(1'b0, 1'b0, '0, '0, '0);
      checks++;
      if (vld_o[2] !== (k >= 3 && k <= 7)) begin
        errors++;
        $display("FAIL acc_valid k=%0d: got %b want %b", k, vld_o[2], (k >= 3 && k <= 7));
      end
      if (k >= 3 && k <= 7) begin
        checks++;
        if (p_o[2] !== exp_p[k-3]) begin
          errors++;
          $display("FAIL acc_p k=%0d: got %0d want %0d", k, p_o[2], exp_p[k-3]);
        end
      end
      advance();
    end
  endtask

  task automatic test_ovf_signed();
    logic [19:0] ta [8];
    logic [19:0] tb [8];
    logic        tv [8];
    logic        tc [8];
    logic [39:0] ep [8];
    logic        eo [8];
    ta = '{20'h80000, 20'h7FFFF, 20'h7FFFF, 20'hFFFFF, 20'd1, 20'd1, 20'd0, 20'd3};
    tb = '{20'h80000, 20'h7FFFF, 20'd2,     20'd1,     20'd1, 20'd1, 20'd0, 20'd4};
    tv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ep = '{40'h40_0000_0000, 40'h7F_FFF0_0001, 40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFE,
           40'h7F_FFFF_FFFF, 40'h80_0000_0000, 40'h80_0000_0000, 40'd12};
    eo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 10; k++) begin
      if (k < 8) set_beat(tv[k], tc[k], ta[k], tb[k], '0);
      else set_beat(1'b0, 1'b0, '0, '0, '0);
      if (k >= 2) begin
        checks += 3;
        if (vld_o[3] !== tv[k-2]) begin
          errors++;
          $display("FAIL ovf_valid beat%0d: got %b want %b", k - 2, vld_o[3], tv[k-2]);
        end
        if (p_o[3] !== ep[k-2]) begin
          errors++;
          $display("FAIL ovf_p beat%0d: got %h want %h", k - 2, p_o[3], ep[k-2]);
        end
        if (ovf_o[3] !== eo[k-2]) begin
          errors++;
          $display("FAIL ovf_flag beat%0d: got %b want %b", k - 2, ovf_o[3], eo[k-2]);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic ev, eo, cp;
    logic [39:0] ep;
    for (int k = 0; k < 40; k++) begin
      en = !(k >= 12 && k < 17);
      rnd_beat();
      for (int d = 0; d < NDut; d++) begin
        expect_out(d, ev, ep, eo, cp);
        checks += 2;
        if (vld_o[d] !== ev || ovf_o[d] !== eo) begin
          errors++;
          $display("FAIL stall_tags dut%0d k=%0d: got v=%b o=%b want v=%b o=%b",
                   d, k, vld_o[d], ovf_o[d], ev, eo);
        end
        if (cp) begin
          checks++;
          if (p_o[d] !== ep) begin
            errors++;
            $display("FAIL stall_p dut%0d k=%0d: got %h want %h", d, k, p_o[d], ep);
          end
        end
      end
      advance();
    end
    en = 1'b1;
  endtask

  task automatic test_srst();
    logic ev, eo, cp;
    logic [39:0] ep;
    for (int k = 0; k < 30; k++) begin
      srst = (k == 15);
      rnd_beat();
      for (int d = 0; d < NDut; d++) begin
        if (k == 16 && d != 1) begin
          checks++;
          if (p_o[d] !== 40'd0 || vld_o[d] !== 1'b0 || ovf_o[d] !== 1'b0) begin
            errors++;
            $display("FAIL srst_clear dut%0d: got p=%h v=%b o=%b want 0/0/0",
                     d, p_o[d], vld_o[d], ovf_o[d]);
          end
        end
        expect_out(d, ev, ep, eo, cp);
        checks += 2;
        if (vld_o[d] !== ev || ovf_o[d] !== eo) begin
          errors++;
          $display("FAIL srst_tags dut%0d k=%0d: got v=%b o=%b want v=%b o=%b",
                   d, k, vld_o[d], ovf_o[d], ev, eo);
        end
        if (cp) begin
          checks++;
          if (p_o[d] !== ep) begin
            errors++;
            $display("FAIL srst_p dut%0d k=%0d: got %h want %h", d, k, p_o[d], ep);
          end
        end
      end
      advance();
    end
    srst = 1'b0;
  endtask

  task automatic test_random();
    logic ev, eo, cp;
    logic [39:0] ep;
    for (int k = 0; k < 250; k++) begin
      en = ($urandom_range(0, 9) != 0);
      rnd_beat();
      for (int d = 0; d < NDut; d++) begin
        expect_out(d, ev, ep, eo, cp);
        checks += 2;
        if (vld_o[d] !== ev || ovf_o[d] !== eo) begin
          errors++;
          $display("FAIL rand_tags dut%0d k=%0d: got v=%b o=%b want v=%b o=%b",
                   d, k, vld_o[d], ovf_o[d], ev, eo);
        end
        if (cp) begin
          checks++;
          if (p_o[d] !== ep) begin
            errors++;
            $display("FAIL rand_p dut%0d k=%0d: got %h want %h", d, k, p_o[d], ep);
          end
        end
      end
      advance();
    end
    en = 1'b1;
  endtask

  initial begin
    srst = 1'b1; en = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; a = '0; b = '0; c = '0;
    drive();
    #1;
    test_reset();
    test_mode0();
    test_mode1_comb();
    test_accum_unsigned();
    test_ovf_signed();
    test_stall();
    test_srst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
